in_debounce_sync: RTL and testbench
===================================

// Module: in_debounce_sync
// PURPOSE
//  Upstream conditioning stage for the single-bit IN consumed by the TOP register bank and SUB.
//  Synchronises an asynchronous input to CLK, then debounces it with a counter FSM.
//  Emits a clean level plus one-cycle RISE/FALL pulses, so downstream flops all sample one stable net.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flop count; must be >= 2
//  DEB_CYCLES   4  consecutive differing samples required to commit a change; must be >= 1
//  CNT_W        8  GLITCH_CNT width; used only with DEB_GLITCH_CNT_EN
//  RST_VAL      0  reset level of synchroniser chain and OUT
// PORTS
//  CLK         in   1      clock
//  RST         in   1      reset, asynchronous, active-low
//  IN          in   1      raw asynchronous input
//  OUT         out  1      debounced level
//  RISE        out  1      one-cycle pulse when OUT goes 0->1
//  FALL        out  1      one-cycle pulse when OUT goes 1->0
//  BUSY        out  1      high while FSM is in WAIT
//  GLITCH_CLR  in   1      synchronous clear of GLITCH_CNT (macro only)
//  GLITCH_CNT  out  CNT_W  rejected-glitch count, saturating (macro only)
// BEHAVIOUR
//  Reset (RST=0, async): sync chain=RST_VAL, OUT=RST_VAL, RISE=FALL=0, BUSY=0, state=STABLE,
//   cnt=0, GLITCH_CNT=0. Reset asserted mid-WAIT aborts the pending change; no pulse is emitted.
//  Synchroniser: s = last flop of the SYNC_STAGES chain; IN feeds only the first flop.
//  cnt width = $clog2(DEB_CYCLES+1); never exceeds DEB_CYCLES.
//  FSM, one transition per CLK edge:
//   STABLE: s==OUT -> stay. s!=OUT -> if DEB_CYCLES==1, commit now; else WAIT, cnt=1.
//   WAIT:   s==OUT -> STABLE, cnt=0, glitch event.
//           s!=OUT, cnt==DEB_CYCLES-1 -> commit.
//           else cnt++.
//   commit: OUT<=s; RISE<=s; FALL<=!s for exactly one cycle; STABLE, cnt=0.
//  RISE/FALL are registered and never both high. They are 0 in every cycle without a commit.
//  BUSY is registered and equals (state==WAIT).
//  Latency: if edge k is the first edge at which the first sync flop captures new IN (held stable),
//   OUT and the pulse update at edge k+SYNC_STAGES+DEB_CYCLES-1 (defaults: k+5).
//  Input held at the current OUT value produces no activity. Toggling every cycle never commits.
//  Release after reset with IN!=RST_VAL is debounced normally (full latency, then pulse).
//  Back-to-back changes: a new difference may start WAIT on the edge after a commit.
// CONFIGURATION
//  Macro DEB_GLITCH_CNT_EN:
//   defined   -> GLITCH_CLR/GLITCH_CNT ports exist.
//                GLITCH_CNT increments by 1 per glitch event and saturates at all-ones.
//                GLITCH_CLR=1 zeroes it at the next edge; clear wins over a simultaneous increment.
//   undefined -> both ports and the counter are absent. FSM/OUT/RISE/FALL timing is identical.
// TESTING
//  1. RST=0 with IN=1, release, hold IN=1 -> OUT=0 until latency elapses,
//     then OUT=1 and RISE=1 for 1 cycle; FALL stays 0.
//  2. Defaults: IN 0->1 captured at edge 10 and held -> BUSY=1 at edges 12..14,
//     OUT=1 and RISE=1 at edge 15, BUSY=0.
//  3. IN=1 for 2 cycles, then back to 0 -> OUT stays 0, RISE/FALL never pulse,
//     GLITCH_CNT 0->1 (macro on).
//  4. OUT=1, IN 1->0 held -> FALL=1 for one cycle at k+5, OUT=0.
//     Immediate IN 0->1 -> RISE at the following latency.
//  5. Assert RST while BUSY=1 -> all outputs reset asynchronously, no pulse.
//     After release with IN=0 (RST_VAL=0) -> no activity.
//  6. Macro on, CNT_W=2: 5 glitches -> GLITCH_CNT=3 (saturated).
//     GLITCH_CLR on the same edge as a 6th glitch -> GLITCH_CNT=0.

Source files
------------

// File: rtl/in_debounce_sync.sv
// in_debounce_sync: synchronises IN, debounces it with a counter FSM, emits OUT plus RISE/FALL pulses.
// Define DEB_GLITCH_CNT_EN to add the GLITCH_CLR/GLITCH_CNT rejected-glitch counter.
module in_debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN,
    output logic             OUT,
    output logic             RISE,
    output logic             FALL,
    output logic             BUSY
`ifdef DEB_GLITCH_CNT_EN
    ,
    input  logic             GLITCH_CLR,
    output logic [CNT_W-1:0] GLITCH_CNT
`endif
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic {S_STABLE, S_WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_state_nx;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic                   w_s, w_commit;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_commit   = 1'b0;
        if (r_state == S_STABLE) begin
            if (w_s != OUT) begin
                if (DEB_CYCLES == 1) begin
                    w_commit = 1'b1;
                end else begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = CW'(1);
                end
            end
        end else if (w_s == OUT) begin
            w_state_nx = S_STABLE;
            w_cnt_nx   = '0;
        end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            w_commit   = 1'b1;
            w_state_nx = S_STABLE;
            w_cnt_nx   = '0;
        end else begin
            w_cnt_nx = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync  <= {SYNC_STAGES{RST_VAL}};
            r_state <= S_STABLE;
            r_cnt   <= '0;
            OUT     <= RST_VAL;
            RISE    <= 1'b0;
            FALL    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], IN};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            OUT     <= w_commit ? w_s : OUT;
            RISE    <= w_commit & w_s;
            FALL    <= w_commit & ~w_s;
            BUSY    <= (w_state_nx == S_WAIT);
        end
    end

`ifdef DEB_GLITCH_CNT_EN
    // A glitch is a WAIT that collapses because the input fell back to OUT.
    logic w_glitch;
    assign w_glitch = (r_state == S_WAIT) && (w_s == OUT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            GLITCH_CNT <= '0;
        else if (GLITCH_CLR)
            GLITCH_CNT <= '0;
        else if (w_glitch && !(&GLITCH_CNT))
            GLITCH_CNT <= GLITCH_CNT + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_in_debounce_sync.sv
// tb_in_debounce_sync: random and directed stimulus against a run-length debounce model, scoreboard-checked.
module tb_in_debounce_sync;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 2;
    localparam bit RV   = 1'b0;

    typedef logic [CW+3:0] exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic IN  = 1'b1;
    logic GLITCH_CLR = 1'b0;
    logic OUT, RISE, FALL, BUSY;
`ifdef DEB_GLITCH_CNT_EN
    logic [CW-1:0] GLITCH_CNT;
`endif

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   hist[$];
    bit   m_s, m_out, m_rise, m_fall, m_busy;
    int   run, m_gc;

    always #5 CLK = ~CLK;

    in_debounce_sync #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(CW), .RST_VAL(RV)
    ) dut (
        .CLK(CLK), .RST(RST), .IN(IN),
        .OUT(OUT), .RISE(RISE), .FALL(FALL), .BUSY(BUSY)
`ifdef DEB_GLITCH_CNT_EN
        , .GLITCH_CLR(GLITCH_CLR), .GLITCH_CNT(GLITCH_CNT)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: the synchroniser is a pure delay of SYNC samples; OUT follows it once it has
    // differed from OUT for DEB consecutive samples; a broken run is a glitch.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(RV);
            m_out = RV; m_busy = 0; run = 0; m_gc = 0;
            q = {};
        end else begin
            m_s = hist.pop_front();
            hist.push_back(IN);
            m_rise = 0; m_fall = 0;
            if (m_s != m_out) begin
                run++;
                if (run == DEB) begin
                    m_out = m_s; m_rise = m_s; m_fall = !m_s; run = 0;
                end
            end else begin
                if (run > 0 && m_gc < (1 << CW) - 1) m_gc++;
                run = 0;
            end
            if (GLITCH_CLR) m_gc = 0;
            m_busy = run > 0;
            q.push_back({m_out, m_rise, m_fall, m_busy, CW'(m_gc)});
        end
    end

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (RST) begin
            if (q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                check("out_rise_fall_busy", {28'd0, OUT, RISE, FALL, BUSY}, {28'd0, e[CW+3:CW]});
`ifdef DEB_GLITCH_CNT_EN
                check("glitch_cnt", 32'(GLITCH_CNT), 32'(e[CW-1:0]));
`endif
            end
        end
    end

    task automatic drive(input bit v, input int n);
        IN = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_reset(input string nm);
        check(nm, {28'd0, OUT, RISE, FALL, BUSY}, {28'd0, RV, 3'b000});
`ifdef DEB_GLITCH_CNT_EN
        check({nm, "_gc"}, 32'(GLITCH_CNT), 32'd0);
`endif
    endtask

    initial begin
        int i;
        RST = 1'b0; IN = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset("reset_state");
        RST = 1'b1;
        drive(1, 10);
        drive(0, 10);
        drive(1, 2);
        drive(0, 8);
        drive(1, 8);
        drive(0, 6);
        drive(1, 10);
        for (int k = 0; k < 12; k++) drive(!IN, 1);
        drive(0, 8);
        repeat (300) begin
            GLITCH_CLR = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 7));
        end
        GLITCH_CLR = 1'b0;
        drive(!m_out, 1);
        for (i = 0; i < 20 && !m_busy; i++) @(negedge CLK);
        if (!m_busy) check("busy_timeout", 32'd0, 32'd1);
        check("busy_before_reset", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        check_reset("async_reset_mid_wait");
        IN = RV;
        repeat (3) @(negedge CLK);
        check_reset("reset_hold");
        RST = 1'b1;
        drive(RV, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
